// File: rtl/vga_snake_controller.sv
// vga_snake_controller: 640x480@60 VGA timing, pixel addressing
// and a single green snake head on a 32x24 board of 20px cells.
module vga_snake_controller #(
  parameter int MOVE_FRAMES = 8,
  parameter int CELL_PIX    = 20,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic        oBLANK_n,
  output logic        oHS,
  output logic        oVS,
  output logic [7:0]  r_data,
  output logic [7:0]  g_data,
  output logic [7:0]  b_data,
  output logic [18:0] ADDR,
  output logic [31:0] addressRow,
  output logic [31:0] addressCol,
  output logic [31:0] boardPosition
);

  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] HE  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VE  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] CP  = 10'(CELL_PIX);
  localparam logic [7:0] MF_LAST = 8'(MOVE_FRAMES - 1);

  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_t;

  logic [9:0] h_cnt, v_cnt;
  logic [7:0] frame_cnt;
  logic [4:0] head_col, head_row;
  dir_t       dir_q, dir_d, req;
  logic       frame_end, step;

  logic       vis;
  logic [9:0] row_pix, col_pix;
  logic [4:0] cell_row, cell_col;
  logic [9:0] board;

  assign frame_end = (h_cnt == HE) && (v_cnt == VE);
  assign step      = frame_end && (frame_cnt == MF_LAST);

  // Raster scan: column counter rolls into the line counter.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HE) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VE) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Frame pacing: one head step every MOVE_FRAMES frames.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) frame_cnt <= '0;
    else if (step) frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  // Direction state register.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) dir_q <= D_RIGHT;
    else dir_q <= dir_d;
  end

  // Next direction: highest-priority button, reversals dropped.
  always_comb begin
    req = dir_q;
    if (up) req = D_UP;
    else if (down) req = D_DOWN;
    else if (left) req = D_LEFT;
    else if (right) req = D_RIGHT;
    dir_d = dir_q;
    if ((req ^ dir_q) != 2'b01) dir_d = req;
  end

  // Head moves one cell per step, wrapping at the board edges.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      head_col <= 5'd16;
      head_row <= 5'd12;
    end else if (step) begin
      unique case (dir_q)
        D_UP:    head_row <= (head_row == 5'd0) ? 5'd23 : head_row - 5'd1;
        D_DOWN:  head_row <= (head_row == 5'd23) ? 5'd0 : head_row + 5'd1;
        D_LEFT:  head_col <= head_col - 5'd1;
        D_RIGHT: head_col <= head_col + 5'd1;
      endcase
    end
  end

  // Pixel outputs decoded straight from the registered counters.
  always_comb begin
    vis           = (h_cnt < HV) && (v_cnt < VV);
    col_pix       = vis ? h_cnt : 10'd0;
    row_pix       = vis ? v_cnt : 10'd0;
    cell_col      = 5'(col_pix / CP);
    cell_row      = 5'(row_pix / CP);
    board         = {cell_row, cell_col};
    oBLANK_n      = vis;
    oHS           = !((h_cnt >= HS0) && (h_cnt < HS1));
    oVS           = !((v_cnt >= VS0) && (v_cnt < VS1));
    ADDR          = 19'(row_pix) * 19'(H_VIS) + 19'(col_pix);
    addressRow    = 32'(row_pix);
    addressCol    = 32'(col_pix);
    boardPosition = 32'(board);
    r_data        = 8'h00;
    b_data        = 8'h00;
    g_data        = (vis && (board == {head_row, head_col})) ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_vga_snake_controller.sv
// tb_vga_snake_controller: scoreboard bench, full-size timing instance
// plus a shrunken-raster instance for frame and head-movement checks.
`timescale 1ns/1ps
module tb_vga_snake_controller;

  localparam int F = 1849;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

  logic        b_blank, b_hs, b_vs;
  logic [7:0]  b_r, b_g, b_b;
  logic [18:0] b_addr;
  logic [31:0] b_row, b_col, b_bp;

  logic        s_blank, s_hs, s_vs;
  logic [7:0]  s_r, s_g, s_b;
  logic [18:0] s_addr;
  logic [31:0] s_row, s_col, s_bp;

  vga_snake_controller b_dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .up(up), .down(down), .left(left), .right(right),
    .oBLANK_n(b_blank), .oHS(b_hs), .oVS(b_vs),
    .r_data(b_r), .g_data(b_g), .b_data(b_b),
    .ADDR(b_addr), .addressRow(b_row), .addressCol(b_col),
    .boardPosition(b_bp)
  );

  vga_snake_controller #(
    .MOVE_FRAMES(1),
    .H_VIS(40), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VIS(40), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) s_dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .up(up), .down(down), .left(left), .right(right),
    .oBLANK_n(s_blank), .oHS(s_hs), .oVS(s_vs),
    .r_data(s_r), .g_data(s_g), .b_data(s_b),
    .ADDR(s_addr), .addressRow(s_row), .addressCol(s_col),
    .boardPosition(s_bp)
  );

  always #10 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  localparam int K_ADDR = 0, K_ROW = 1, K_COL = 2, K_BP = 3;
  localparam int K_SYNC = 4, K_RGB = 5, K_HEAD = 6;

  typedef struct {
    int          cyc;
    bit          inst;
    int          kind;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic expect_at(int c, bit inst, int kind,
                           logic [63:0] e, string nm);
    chk_t t;
    int i;
    t.cyc = c; t.inst = inst; t.kind = kind; t.exp = e; t.name = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, t);
  endtask

  function automatic logic [63:0] hd(int r, int c);
    return 64'(r * 32 + c);
  endfunction

  function automatic logic [63:0] obs(bit inst, int kind);
    case (kind)
      K_ADDR: return inst ? 64'(s_addr) : 64'(b_addr);
      K_ROW:  return inst ? 64'(s_row) : 64'(b_row);
      K_COL:  return inst ? 64'(s_col) : 64'(b_col);
      K_BP:   return inst ? 64'(s_bp) : 64'(b_bp);
      K_SYNC: return inst ? 64'({s_blank, s_hs, s_vs})
                          : 64'({b_blank, b_hs, b_vs});
      K_RGB:  return inst ? 64'({s_r, s_g, s_b}) : 64'({b_r, b_g, b_b});
      K_HEAD: return 64'({s_dut.head_row, s_dut.head_col});
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    chk_t t;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        t = q.pop_front();
        a = obs(t.inst, t.kind);
        checks++;
        if (t.cyc != cyc) begin
          errors++;
          $display("FAIL %s: not sampled at cycle %0d (now %0d)",
                   t.name, t.cyc, cyc);
        end else if (a !== t.exp) begin
          errors++;
          $display("FAIL %s @%0d: got %0h want %0h",
                   t.name, cyc, a, t.exp);
        end
      end
    end
  end

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d checks left after %0d cycles",
               q.size(), budget);
      errors += q.size();
      checks += q.size();
      q.delete();
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(int which, int c, int n);
    wait_cyc(c);
    case (which)
      0: up = 1'b1;
      1: down = 1'b1;
      2: left = 1'b1;
      default: right = 1'b1;
    endcase
    repeat (n) @(negedge clk);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic expect_reset();
    expect_at(0, 0, K_ADDR, 0, "b_rst_addr");
    expect_at(0, 0, K_ROW, 0, "b_rst_row");
    expect_at(0, 0, K_COL, 0, "b_rst_col");
    expect_at(0, 0, K_BP, 0, "b_rst_bp");
    expect_at(0, 0, K_SYNC, 3'b111, "b_rst_sync");
    expect_at(0, 0, K_RGB, 0, "b_rst_rgb");
    expect_at(0, 1, K_ADDR, 0, "s_rst_addr");
    expect_at(0, 1, K_SYNC, 3'b111, "s_rst_sync");
  endtask

  initial begin
    expect_reset();
    expect_at(1, 0, K_ADDR, 1, "b_first_addr");
    expect_at(5, 0, K_RGB, 0, "b_black_pix");
    expect_at(25, 0, K_ADDR, 25, "b_addr25");
    expect_at(25, 0, K_COL, 25, "b_col25");
    expect_at(25, 0, K_BP, 1, "b_bp25");
    expect_at(400, 0, K_BP, 20, "b_bp400");
    expect_at(639, 0, K_ADDR, 639, "b_addr639");
    expect_at(639, 0, K_BP, 31, "b_bp639");
    expect_at(639, 0, K_SYNC, 3'b111, "b_sync639");
    expect_at(640, 0, K_SYNC, 3'b011, "b_sync640");
    expect_at(640, 0, K_ADDR, 0, "b_addr640");
    expect_at(640, 0, K_COL, 0, "b_col640");
    expect_at(640, 0, K_BP, 0, "b_bp640");
    expect_at(655, 0, K_SYNC, 3'b011, "b_sync655");
    expect_at(656, 0, K_SYNC, 3'b001, "b_sync656");
    expect_at(751, 0, K_SYNC, 3'b001, "b_sync751");
    expect_at(752, 0, K_SYNC, 3'b011, "b_sync752");
    expect_at(800, 0, K_ADDR, 640, "b_addr800");
    expect_at(800, 0, K_ROW, 1, "b_row800");
    expect_at(800, 0, K_COL, 0, "b_col800");
    expect_at(800, 0, K_BP, 0, "b_bp800");
    expect_at(40, 1, K_SYNC, 3'b011, "s_hfp");
    expect_at(41, 1, K_SYNC, 3'b001, "s_hsync");
    expect_at(42, 1, K_SYNC, 3'b011, "s_hbp");
    expect_at(860, 1, K_ADDR, 800, "s_addr_r20");
    expect_at(860, 1, K_ROW, 20, "s_row_r20");
    expect_at(860, 1, K_BP, 32, "s_bp_r20");
    expect_at(1716, 1, K_ADDR, 1599, "s_last_addr");
    expect_at(1716, 1, K_BP, 33, "s_last_bp");
    expect_at(1720, 1, K_SYNC, 3'b011, "s_vfp");
    expect_at(1763, 1, K_SYNC, 3'b010, "s_vsync0");
    expect_at(1805, 1, K_SYNC, 3'b010, "s_vsync1");
    expect_at(1806, 1, K_SYNC, 3'b011, "s_vbp");
    expect_at(F - 1, 1, K_HEAD, hd(12, 16), "s_head_init");
    expect_at(F, 1, K_ADDR, 0, "s_wrap_addr");
    expect_at(F, 1, K_SYNC, 3'b111, "s_wrap_sync");
    expect_at(F, 1, K_HEAD, hd(12, 17), "s_head_step1");
    expect_at(F + 1, 1, K_ADDR, 1, "s_wrap_addr1");

    #25 rst_n = 1'b1;
    wait_drain(2500);

    wait_cyc(2500);
    @(posedge clk);
    #3 rst_n = 1'b0;
    expect_reset();
    wait_drain(5);
    @(negedge clk);

    expect_at(1, 0, K_ADDR, 1, "b_rearm_addr");
    expect_at(F, 1, K_HEAD, hd(12, 17), "left_ignored");
    expect_at(2 * F, 1, K_HEAD, hd(11, 17), "up_step");
    expect_at(4 * F, 1, K_HEAD, hd(9, 17), "down_ignored");
    expect_at(13 * F, 1, K_HEAD, hd(0, 17), "row_top");
    expect_at(14 * F, 1, K_HEAD, hd(23, 17), "row_wrap");
    expect_at(28 * F, 1, K_HEAD, hd(23, 31), "col_right");
    expect_at(29 * F, 1, K_HEAD, hd(23, 0), "col_wrap");
    expect_at(29 * F + 220, 1, K_RGB, 0, "rgb_no_head");
    expect_at(30 * F, 1, K_HEAD, hd(0, 0), "down_wrap");
    expect_at(30 * F + 220, 1, K_RGB, 24'h00FF00, "rgb_head");
    expect_at(30 * F + 240, 1, K_RGB, 0, "rgb_beside");
    #5 rst_n = 1'b1;

    press(2, 100, 4);
    press(0, F + 100, 4);
    press(1, 3 * F + 100, 4);
    press(3, 14 * F + 100, 4);
    press(1, 29 * F + 100, 4);
    wait_drain(F + 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
